alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute stage of the in-order RV32I pipeline: fetch, decode/cpureg, alu_exec, write-back.
- Takes decoded fields plus register-file operands and computes the ALU result, memory address or link value. Resolves branches and jumps.
- Outputs are registered behind a valid/next handshake, and the block raises a one-cycle redirect (c_flush/c_pc) to fetch and decode.

Parameters:
- XLEN, 32, datapath width (only 32 supported).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  decode holds a valid instruction.
- i_next  out  1  ready: upstream instruction is consumed on this edge when i_valid && i_next.
- i_rs1en / i_rs2en  in  1  operand A = rs1 (else 0); operand B = rs2 (else i_imm).
- i_rs1 / i_rs2  in  32  register values, valid in the same cycle as i_valid.
- i_imm  in  32  sign-extended immediate.
- i_opcode  in  5  operation code (see package).
- i_memen / i_regen  in  1  memory access / register write-back requested.
- i_memstrb  in  3  funct3 width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
- i_pc  in  33  [31:0] instruction address; [32] fetch tag, ignored.
- i_rd  in  5  destination register.
- c_flush  out  1  redirect pulse to fetch and decode.
- c_pc  out  32  redirect target, valid while c_flush=1.
- o_valid  out  1  output register holds a result.
- o_next  in  1  downstream accepts; transfer on o_valid && o_next.
- o_regen, o_memen  out  1  registered enables.
- o_memstrb  out  3  registered i_memstrb.
- o_data  out  32  ALU result, link value or memory address.
- o_memdata  out  32  store data (rs2).
- o_rd  out  5  destination register.

Behaviour:
- Reset: all outputs 0; i_next=1 once out of reset.
- Operands: A = i_rs1en ? i_rs1 : 0; B = i_rs2en ? i_rs2 : i_imm.
- Opcodes:
  - ADD A+B; SUB A-B.
  - SLL A<<B[4:0]; SRL logical; SRA arithmetic.
  - SLT signed, SLTU unsigned (result 0/1).
  - XOR, OR, AND.
  - LUI imm; AUIPC pc+imm.
  - JAL: data=pc+4, target pc+imm. JALR: data=pc+4, target (rs1+imm)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU compare rs1 vs rs2; target pc+imm; o_regen=0.
  - LOAD: data=rs1+imm, memen=1, regen=i_regen. STORE: data=rs1+imm, memdata=rs2, memen=1, regen=0.
  - Undefined opcode: data=0, regen=0, memen=0.
- All arithmetic is mod 2^32. o_regen is forced 0 when i_rd==0.
- Latency 1: result registered on the accept edge. i_next = (!o_valid || o_next) && !c_flush.
- Output holds stable while o_valid && !o_next. On o_next without a new accept, o_valid drops to 0.
- Redirect: a taken branch, JAL or JALR sets c_flush=1 and c_pc=target for exactly the one cycle after acceptance, in the same cycle o_valid shows that instruction. Fetch predicts sequential, so every taken control transfer flushes.
- While c_flush=1, i_valid is ignored (wrong-path) and nothing is accepted.
- Back-to-back: a new accept in the same cycle as o_next is allowed (full throughput).
- Reset mid-operation: pending result and flush are discarded immediately.

Decomposition:
- Package alu_pkg: 5-bit opcode constants (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI=10, AUIPC=11, JAL=12, JALR=13, BEQ=14, BNE=15, BLT=16, BGE=17, BLTU=18, BGEU=19, LOAD=20, STORE=21) and memstrb codes.
- One combinational sub-module alu_core: operands/opcode/pc in; result, taken and target out. Handshake and registers stay in alu_exec.

Test Plan:
- ADD rs1=5, imm=7, rs2en=0, rd=3, o_next=1: next cycle o_valid=1, o_data=12, o_rd=3, o_regen=1, c_flush=0.
- SRA rs1=0x80000000, rs2=4: o_data=0xF8000000. SLTU 1 vs 0xFFFFFFFF: o_data=1.
- BEQ pc=0x100, rs1=rs2=9, imm=0x20: c_flush=1 for one cycle, c_pc=0x120, o_regen=0; an i_valid offered that cycle is not accepted. BNE with the same operands: no flush.
- JALR pc=0x40, rs1=0x203, imm=0, rd=1: o_data=0x44, c_pc=0x202.
- STORE rs1=0x1000, imm=4, rs2=0xAB, memstrb=2: o_data=0x1004, o_memdata=0xAB, o_memen=1, o_regen=0, o_memstrb=2.
- Backpressure: o_next=0 for 3 cycles → outputs stable, i_next=0. ADD with rd=0 → o_regen=0. rst_n low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_exec shared types: opcode encoding for the execute stage
// and funct3 memory width codes carried alongside loads/stores.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SLT   = 5'd3,
    OP_SLTU  = 5'd4,
    OP_XOR   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_OR    = 5'd8,
    OP_AND   = 5'd9,
    OP_LUI   = 5'd10,
    OP_AUIPC = 5'd11,
    OP_JAL   = 5'd12,
    OP_JALR  = 5'd13,
    OP_BEQ   = 5'd14,
    OP_BNE   = 5'd15,
    OP_BLT   = 5'd16,
    OP_BGE   = 5'd17,
    OP_BLTU  = 5'd18,
    OP_BGEU  = 5'd19,
    OP_LOAD  = 5'd20,
    OP_STORE = 5'd21
  } alu_op_e;

  typedef enum logic [2:0] {
    MS_B  = 3'd0,
    MS_H  = 3'd1,
    MS_W  = 3'd2,
    MS_BU = 3'd4,
    MS_HU = 3'd5
  } memstrb_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op, operands a/b, raw rs1/rs2, imm, pc in;
// result, branch taken/target, write-back and memory flags out.
module alu_core
  import alu_pkg::*;
(
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            wr,
  output logic            mem
);

  logic [XLEN-1:0] link;
  logic [XLEN-1:0] pcimm;
  logic [XLEN-1:0] addr;
  logic            eq;
  logic            lts;
  logic            ltu;

  assign link  = pc + 32'd4;
  assign pcimm = pc + imm;
  assign addr  = a + imm;
  assign eq    = rs1 == rs2;
  assign lts   = $signed(rs1) < $signed(rs2);
  assign ltu   = rs1 < rs2;

  always_comb begin
    result = '0;
    taken  = 1'b0;
    target = pcimm;
    wr     = 1'b0;
    mem    = 1'b0;
    unique case (op)
      OP_ADD:   begin result = a + b; wr = 1'b1; end
      OP_SUB:   begin result = a - b; wr = 1'b1; end
      OP_SLL:   begin result = a << b[4:0]; wr = 1'b1; end
      OP_SRL:   begin result = a >> b[4:0]; wr = 1'b1; end
      OP_SRA:   begin
        result = $signed(a) >>> b[4:0];
        wr     = 1'b1;
      end
      OP_SLT:   begin
        result = {31'd0, $signed(a) < $signed(b)};
        wr     = 1'b1;
      end
      OP_SLTU:  begin result = {31'd0, a < b}; wr = 1'b1; end
      OP_XOR:   begin result = a ^ b; wr = 1'b1; end
      OP_OR:    begin result = a | b; wr = 1'b1; end
      OP_AND:   begin result = a & b; wr = 1'b1; end
      OP_LUI:   begin result = imm; wr = 1'b1; end
      OP_AUIPC: begin result = pcimm; wr = 1'b1; end
      OP_JAL:   begin
        result = link;
        taken  = 1'b1;
        wr     = 1'b1;
      end
      OP_JALR:  begin
        result = link;
        taken  = 1'b1;
        target = {addr[31:1], 1'b0};
        wr     = 1'b1;
      end
      OP_BEQ:   taken = eq;
      OP_BNE:   taken = !eq;
      OP_BLT:   taken = lts;
      OP_BGE:   taken = !lts;
      OP_BLTU:  taken = ltu;
      OP_BGEU:  taken = !ltu;
      OP_LOAD:  begin result = addr; mem = 1'b1; wr = 1'b1; end
      OP_STORE: begin result = addr; mem = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: registers alu_core results behind valid/next and
// pulses c_flush/c_pc for one cycle after a taken control transfer.
module alu_exec
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            i_next,
  input  logic            i_rs1en,
  input  logic            i_rs2en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_opcode,
  input  logic            i_memen,
  input  logic            i_regen,
  input  logic [2:0]      i_memstrb,
  input  logic [XLEN:0]   i_pc,
  input  logic [4:0]      i_rd,
  output logic            c_flush,
  output logic [XLEN-1:0] c_pc,
  output logic            o_valid,
  input  logic            o_next,
  output logic            o_regen,
  output logic            o_memen,
  output logic [2:0]      o_memstrb,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_memdata,
  output logic [4:0]      o_rd
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            wr;
  logic            mem;
  logic            accept;
  logic            unused_in;

  // Fetch tag and the decoder's memen hint carry nothing the
  // opcode does not already say.
  assign unused_in = i_pc[XLEN] ^ i_memen;

  assign a = i_rs1en ? i_rs1 : '0;
  assign b = i_rs2en ? i_rs2 : i_imm;

  alu_core u_core (
    .op     (i_opcode),
    .a      (a),
    .b      (b),
    .rs1    (i_rs1),
    .rs2    (i_rs2),
    .imm    (i_imm),
    .pc     (i_pc[XLEN-1:0]),
    .result (result),
    .taken  (taken),
    .target (target),
    .wr     (wr),
    .mem    (mem)
  );

  // The flush cycle drops the wrong-path instruction on offer.
  assign i_next = rst_n && (!o_valid || o_next) && !c_flush;
  assign accept = i_valid && i_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flush   <= 1'b0;
      c_pc      <= '0;
      o_valid   <= 1'b0;
      o_regen   <= 1'b0;
      o_memen   <= 1'b0;
      o_memstrb <= '0;
      o_data    <= '0;
      o_memdata <= '0;
      o_rd      <= '0;
    end else begin
      c_flush <= accept && taken;
      if (accept && taken) c_pc <= target;
      if (accept) begin
        o_valid   <= 1'b1;
        o_regen   <= wr && i_regen && (i_rd != 5'd0);
        o_memen   <= mem;
        o_memstrb <= i_memstrb;
        o_data    <= result;
        o_memdata <= i_rs2;
        o_rd      <= i_rd;
      end else if (o_next) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors for ALU ops,
// branches/jumps with flush, stores, backpressure and reset.
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_next;
  logic        i_rs1en;
  logic        i_rs2en;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] i_imm;
  logic [4:0]  i_opcode;
  logic        i_memen;
  logic        i_regen;
  logic [2:0]  i_memstrb;
  logic [32:0] i_pc;
  logic [4:0]  i_rd;
  logic        c_flush;
  logic [31:0] c_pc;
  logic        o_valid;
  logic        o_next;
  logic        o_regen;
  logic        o_memen;
  logic [2:0]  o_memstrb;
  logic [31:0] o_data;
  logic [31:0] o_memdata;
  logic [4:0]  o_rd;

  int checks = 0;
  int errors = 0;

  alu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_next    (i_next),
    .i_rs1en   (i_rs1en),
    .i_rs2en   (i_rs2en),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_imm     (i_imm),
    .i_opcode  (i_opcode),
    .i_memen   (i_memen),
    .i_regen   (i_regen),
    .i_memstrb (i_memstrb),
    .i_pc      (i_pc),
    .i_rd      (i_rd),
    .c_flush   (c_flush),
    .c_pc      (c_pc),
    .o_valid   (o_valid),
    .o_next    (o_next),
    .o_regen   (o_regen),
    .o_memen   (o_memen),
    .o_memstrb (o_memstrb),
    .o_data    (o_data),
    .o_memdata (o_memdata),
    .o_rd      (o_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_ins(input logic [4:0]  op,
                         input logic        r1en,
                         input logic [31:0] r1,
                         input logic        r2en,
                         input logic [31:0] r2,
                         input logic [31:0] imm,
                         input logic [31:0] pc,
                         input logic [4:0]  rd,
                         input logic        regen,
                         input logic        memen,
                         input logic [2:0]  ms);
    i_opcode  = op;
    i_rs1en   = r1en;
    i_rs1     = r1;
    i_rs2en   = r2en;
    i_rs2     = r2;
    i_imm     = imm;
    i_pc      = {1'b1, pc};
    i_rd      = rd;
    i_regen   = regen;
    i_memen   = memen;
    i_memstrb = ms;
    i_valid   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    o_next  = 1'b1;
    i_valid = 1'b0;
    set_ins(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_valid = 1'b0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_flush", c_flush, 0);
    chk("rst_data", o_data, 0);
    chk("rst_inext", i_next, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("inext_up", i_next, 1);

    set_ins(OP_ADD, 1, 5, 0, 0, 7, 0, 3, 1, 0, 0);
    go();
    chk("add_valid", o_valid, 1);
    chk("add_data", o_data, 12);
    chk("add_rd", o_rd, 3);
    chk("add_regen", o_regen, 1);
    chk("add_flush", c_flush, 0);
    step();
    chk("drain_valid", o_valid, 0);

    set_ins(OP_SRA, 1, 32'h8000_0000, 1, 4, 0, 0, 2, 1, 0, 0);
    go();
    chk("sra", o_data, 32'hF800_0000);
    set_ins(OP_SLTU, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 2, 1, 0, 0);
    go();
    chk("sltu", o_data, 1);
    set_ins(OP_SLT, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 2, 1, 0, 0);
    go();
    chk("slt", o_data, 0);
    set_ins(OP_SUB, 1, 3, 1, 5, 0, 0, 2, 1, 0, 0);
    go();
    chk("sub", o_data, 32'hFFFF_FFFE);
    set_ins(OP_LUI, 0, 0, 0, 0, 32'h1234_5000, 0, 2, 1, 0, 0);
    go();
    chk("lui", o_data, 32'h1234_5000);
    set_ins(OP_AUIPC, 0, 0, 0, 0, 32'h1000, 32'h10, 2, 1, 0, 0);
    go();
    chk("auipc", o_data, 32'h1010);

    set_ins(OP_BEQ, 1, 9, 1, 9, 32'h20, 32'h100, 5, 1, 0, 0);
    go();
    chk("beq_flush", c_flush, 1);
    chk("beq_pc", c_pc, 32'h120);
    chk("beq_regen", o_regen, 0);
    chk("beq_valid", o_valid, 1);
    chk("beq_inext", i_next, 0);
    set_ins(OP_ADD, 1, 1, 0, 0, 99, 0, 7, 1, 0, 0);
    go();
    chk("wp_flush", c_flush, 0);
    chk("wp_valid", o_valid, 0);

    set_ins(OP_BNE, 1, 9, 1, 9, 32'h20, 32'h100, 5, 1, 0, 0);
    go();
    chk("bne_flush", c_flush, 0);
    chk("bne_valid", o_valid, 1);

    set_ins(OP_JALR, 1, 32'h203, 0, 0, 0, 32'h40, 1, 1, 0, 0);
    go();
    chk("jalr_data", o_data, 32'h44);
    chk("jalr_pc", c_pc, 32'h202);
    chk("jalr_flush", c_flush, 1);
    chk("jalr_regen", o_regen, 1);
    step();
    chk("flush_1cyc", c_flush, 0);

    set_ins(OP_JAL, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h200, 1, 1, 0, 0);
    go();
    chk("jal_data", o_data, 32'h204);
    chk("jal_pc", c_pc, 32'h1F8);
    step();
    set_ins(OP_BLT, 1, 1, 1, 32'hFFFF_FFFF, 8, 32'h300, 0, 0, 0, 0);
    go();
    chk("blt_nt", c_flush, 0);
    set_ins(OP_BGEU, 1, 1, 1, 32'hFFFF_FFFF, 8, 32'h300, 0, 0, 0, 0);
    go();
    chk("bgeu_nt", c_flush, 0);
    set_ins(OP_BLTU, 1, 1, 1, 32'hFFFF_FFFF, 8, 32'h300, 0, 0, 0, 0);
    go();
    chk("bltu_t", c_flush, 1);
    chk("bltu_pc", c_pc, 32'h308);
    step();

    set_ins(OP_STORE, 1, 32'h1000, 0, 32'hAB, 4, 0, 0, 0, 1, 3'd2);
    go();
    chk("st_data", o_data, 32'h1004);
    chk("st_mdata", o_memdata, 32'hAB);
    chk("st_memen", o_memen, 1);
    chk("st_regen", o_regen, 0);
    chk("st_strb", o_memstrb, 2);
    set_ins(OP_LOAD, 1, 32'h2000, 0, 0, 32'hFFFF_FFFC, 0, 8, 1, 1, 3'd4);
    go();
    chk("ld_data", o_data, 32'h1FFC);
    chk("ld_regen", o_regen, 1);
    chk("ld_strb", o_memstrb, 4);

    set_ins(5'd31, 1, 5, 1, 6, 7, 0, 9, 1, 1, 0);
    go();
    chk("undef_data", o_data, 0);
    chk("undef_regen", o_regen, 0);
    chk("undef_memen", o_memen, 0);

    set_ins(OP_ADD, 1, 5, 0, 0, 7, 0, 0, 1, 0, 0);
    go();
    chk("rd0_regen", o_regen, 0);
    step();

    o_next = 1'b0;
    set_ins(OP_ADD, 1, 5, 0, 0, 1, 0, 4, 1, 0, 0);
    step();
    set_ins(OP_SUB, 1, 9, 1, 2, 0, 0, 6, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, 6);
      chk("bp_rd", o_rd, 4);
      chk("bp_inext", i_next, 0);
      step();
    end
    o_next = 1'b1;
    #1;
    chk("bp_release", i_next, 1);
    go();
    chk("bb_data", o_data, 7);
    chk("bb_rd", o_rd, 6);

    set_ins(OP_JAL, 0, 0, 0, 0, 32'h40, 32'h80, 1, 1, 0, 0);
    go();
    chk("pre_rst_flush", c_flush, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_flush", c_flush, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_pc", c_pc, 0);
    chk("mid_rst_regen", o_regen, 0);
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
